// File: rtl/ss_bus_sequencer.sv
`timescale 1ns/1ps
// Savestate bus master: copies NUM_REGS 64-bit mapper slots to memory on save, and back on load.
// Latency: save 3 cycles/slot, load 2 cycles/slot plus rst and load strobes; both plus memory wait.
// Backpressure: a single memory request is held until mem_ack; abort with an error pulse after TIMEOUT cycles.
module ss_bus_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int BASE_ADR = 0,
  parameter int MEM_AW   = 16,
  parameter int MEM_BASE = 0,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_req,
  input  logic              load_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [63:0]       SaveStateBus_Din,
  output logic [9:0]        SaveStateBus_Adr,
  output logic              SaveStateBus_wren,
  output logic              SaveStateBus_rst,
  output logic              SaveStateBus_load,
  input  logic [63:0]       SaveStateBus_Dout,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int SW = $clog2(NUM_REGS) + 1;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_REGS - 1);
  localparam logic [TW-1:0] CNT_LAST  = TW'(TIMEOUT - 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_S_ADDR = 4'd1;
  localparam logic [3:0] ST_S_CAP  = 4'd2;
  localparam logic [3:0] ST_S_WAIT = 4'd3;
  localparam logic [3:0] ST_L_RST  = 4'd4;
  localparam logic [3:0] ST_L_RD   = 4'd5;
  localparam logic [3:0] ST_L_WR   = 4'd6;
  localparam logic [3:0] ST_L_LOAD = 4'd7;
  localparam logic [3:0] ST_FIN    = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          error_q, error_d;

  logic          in_wait;
  logic          bus_adr_active;
  logic          bus_din_active;

  // Next-state logic: slot walk, memory handshake and timeout abort.
  // On the last slot the slot index is left in place so L_LOAD can keep Adr stable.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = '0;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (save_req) begin
          state_d = ST_S_ADDR;
        end else if (load_req) begin
          state_d = ST_L_RST;
        end
      end
      ST_S_ADDR: state_d = ST_S_CAP;
      ST_S_CAP: begin
        wdata_d = SaveStateBus_Dout;
        state_d = ST_S_WAIT;
      end
      ST_S_WAIT: begin
        if (mem_ack) begin
          if (slot_q == LAST_SLOT) begin
            state_d = ST_FIN;
          end else begin
            slot_d  = slot_q + SW'(1);
            state_d = ST_S_ADDR;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          slot_d  = '0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_L_RST: state_d = ST_L_RD;
      ST_L_RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = ST_L_WR;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          slot_d  = '0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_L_WR: begin
        if (slot_q == LAST_SLOT) begin
          state_d = ST_L_LOAD;
        end else begin
          slot_d  = slot_q + SW'(1);
          state_d = ST_L_RD;
        end
      end
      ST_L_LOAD: state_d = ST_FIN;
      ST_FIN: begin
        slot_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        slot_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any operation without touching memory further.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign in_wait        = (state_q == ST_S_WAIT) || (state_q == ST_L_RD);
  assign bus_adr_active = (state_q == ST_S_ADDR) || (state_q == ST_S_CAP) ||
                          (state_q == ST_L_WR)   || (state_q == ST_L_LOAD);
  assign bus_din_active = (state_q == ST_L_WR)   || (state_q == ST_L_LOAD);

  // Bus address and data are forced to zero outside active cycles so mappers never see stray values.
  assign SaveStateBus_Adr  = bus_adr_active ? (10'(BASE_ADR) + 10'(slot_q)) : 10'd0;
  assign SaveStateBus_Din  = bus_din_active ? rdata_q : 64'd0;
  assign SaveStateBus_wren = (state_q == ST_L_WR);
  assign SaveStateBus_rst  = (state_q == ST_L_RST);
  assign SaveStateBus_load = (state_q == ST_L_LOAD);

  assign mem_addr  = in_wait ? (MEM_AW'(MEM_BASE) + MEM_AW'(slot_q)) : '0;
  assign mem_wdata = wdata_q;
  assign mem_wr    = (state_q == ST_S_WAIT);
  assign mem_rd    = (state_q == ST_L_RD);

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done  = (state_q == ST_FIN);
  assign error = error_q;

endmodule

// File: tb/tb_ss_bus_sequencer.sv
`timescale 1ns/1ps
// Bench for ss_bus_sequencer: mapper slot model and latency-controlled memory model around a 4-slot instance,
// plus a second 4-slot instance with TIMEOUT=8 whose memory ack is driven directly.
// Directed scenarios with hand-computed expectations; one summary line at the end.
module tb_ss_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        reset_n, save_req, load_req;
  logic        busy, done, error;
  logic [63:0] ss_din, ss_dout;
  logic [9:0]  ss_adr;
  logic        ss_wren, ss_rst, ss_load;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rd, mem_wr;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_ack = 1'b0;

  logic        save_req_t, load_req_t;
  logic        busy_t, done_t, error_t;
  logic [63:0] ss_din_t;
  logic [9:0]  ss_adr_t;
  logic        ss_wren_t, ss_rst_t, ss_load_t;
  logic [15:0] mem_addr_t;
  logic [63:0] mem_wdata_t, mem_rdata_t;
  logic        mem_rd_t, mem_wr_t, mem_ack_t;
  logic [63:0] ss_dout_t;

  ss_bus_sequencer #(.NUM_REGS(4), .BASE_ADR(0), .MEM_AW(16), .MEM_BASE(0), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .save_req(save_req), .load_req(load_req),
    .busy(busy), .done(done), .error(error),
    .SaveStateBus_Din(ss_din), .SaveStateBus_Adr(ss_adr), .SaveStateBus_wren(ss_wren),
    .SaveStateBus_rst(ss_rst), .SaveStateBus_load(ss_load), .SaveStateBus_Dout(ss_dout),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  ss_bus_sequencer #(.NUM_REGS(4), .BASE_ADR(0), .MEM_AW(16), .MEM_BASE(0), .TIMEOUT(8)) dut_t (
    .clk(clk), .reset_n(reset_n), .save_req(save_req_t), .load_req(load_req_t),
    .busy(busy_t), .done(done_t), .error(error_t),
    .SaveStateBus_Din(ss_din_t), .SaveStateBus_Adr(ss_adr_t), .SaveStateBus_wren(ss_wren_t),
    .SaveStateBus_rst(ss_rst_t), .SaveStateBus_load(ss_load_t), .SaveStateBus_Dout(ss_dout_t),
    .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_rd(mem_rd_t), .mem_wr(mem_wr_t),
    .mem_rdata(mem_rdata_t), .mem_ack(mem_ack_t)
  );

  // Mapper model: 4 savestate slots, live registers, strobe counters and a wren log.
  logic [63:0] slot_val [4];
  logic [63:0] live [4];
  logic [63:0] init_slot [4];
  logic        init_slot_req = 1'b0;
  int          wren_cnt = 0, rst_cnt = 0, load_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  int          load_cnt_t = 0, done_cnt_t = 0;
  logic [9:0]  wren_adr_log [64];
  logic [63:0] wren_din_log [64];
  logic [9:0]  load_adr;
  logic [63:0] load_din;

  assign ss_dout = (ss_adr < 10'd4) ? slot_val[ss_adr[1:0]] : 64'd0;

  always @(posedge clk) begin
    if (init_slot_req) begin
      for (int k = 0; k < 4; k++) slot_val[k] <= init_slot[k];
    end else if (ss_rst) begin
      for (int k = 0; k < 4; k++) slot_val[k] <= 64'hD0D0_0000_0000_0000 + 64'(k);
    end else if (ss_wren && ss_adr < 10'd4) begin
      slot_val[ss_adr[1:0]] <= ss_din;
    end
    if (ss_load) begin
      for (int k = 0; k < 4; k++) live[k] <= slot_val[k];
      load_cnt <= load_cnt + 1;
      load_adr <= ss_adr;
      load_din <= ss_din;
    end
    if (ss_wren) begin
      wren_adr_log[wren_cnt[5:0]] <= ss_adr;
      wren_din_log[wren_cnt[5:0]] <= ss_din;
      wren_cnt <= wren_cnt + 1;
    end
    if (ss_rst) rst_cnt <= rst_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (ss_load && (ss_wren || ss_rst)) overlap_cnt <= overlap_cnt + 1;
    if (ss_load_t) load_cnt_t <= load_cnt_t + 1;
    if (done_t) done_cnt_t <= done_cnt_t + 1;
  end

  // Memory model: 4 words, ack after lat_cur cycles of a held request.
  logic [63:0] mem [4];
  logic [63:0] init_mem [4];
  logic        init_mem_req = 1'b0;
  int          memwr_cnt = 0;
  int          wait_cnt = 0;
  int          lat_cur = 0;
  int          fixed_lat = 0;
  logic        rand_lat = 1'b0;

  always @(posedge clk) begin
    if (init_mem_req) begin
      for (int k = 0; k < 4; k++) mem[k] <= init_mem[k];
    end else if (mem_wr && mem_ack && mem_addr < 16'd4) begin
      mem[mem_addr[1:0]] <= mem_wdata;
    end
    if (mem_wr && mem_ack) memwr_cnt <= memwr_cnt + 1;
  end

  always @(negedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ack) begin
      if (wait_cnt >= lat_cur) begin
        mem_ack   <= 1'b1;
        mem_rdata <= (mem_addr < 16'd4) ? mem[mem_addr[1:0]] : 64'd0;
        wait_cnt  <= 0;
        lat_cur   <= rand_lat ? int'($urandom_range(20, 0)) : fixed_lat;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end
  end

  assign ss_dout_t = 64'd0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_slots(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    init_slot[0] = a; init_slot[1] = b; init_slot[2] = c; init_slot[3] = d;
    init_slot_req = 1'b1;
    tick;
    init_slot_req = 1'b0;
  endtask

  task automatic set_mem(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    init_mem[0] = a; init_mem[1] = b; init_mem[2] = c; init_mem[3] = d;
    init_mem_req = 1'b1;
    tick;
    init_mem_req = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    save_req = 1'b0; load_req = 1'b0;
    save_req_t = 1'b0; load_req_t = 1'b0;
    mem_ack_t = 1'b0; mem_rdata_t = 64'd0;
    tick; tick;
    checks++;
    if ({busy, done, error, ss_wren, ss_rst, ss_load, mem_rd, mem_wr} !== 8'd0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000000", {busy, done, error, ss_wren, ss_rst, ss_load, mem_rd, mem_wr});
    end
    checks++;
    if (ss_adr !== 10'd0 || ss_din !== 64'd0) begin
      failures++;
      $display("FAIL reset_bus got adr=%0h din=%0h want 0/0", ss_adr, ss_din);
    end
    checks++;
    if (mem_addr !== 16'd0 || mem_wdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_mem got addr=%0h wdata=%0h want 0/0", mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    tick; tick;
    checks++;
    if (busy !== 1'b0 || busy_t !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b busy_t=%b want 0/0", busy, busy_t);
    end
  endtask

  task automatic test_save;
    int n;
    int mw0;
    logic [63:0] ev [4];
    ev[0] = 64'h0000_0000_05AC_3E17; ev[1] = 64'h1234_5678_9ABC_DEF0;
    ev[2] = 64'hFFFF_0000_FFFF_0000; ev[3] = 64'h0000_0001_0000_0001;
    load_slots(ev[0], ev[1], ev[2], ev[3]);
    set_mem(64'd0, 64'd0, 64'd0, 64'd0);
    fixed_lat = 0;
    mw0 = memwr_cnt;
    save_req = 1'b1;
    tick;
    save_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL save_busy_after_accept got=%b want=1", busy);
    end
    n = 1;
    while (done !== 1'b1 && n < 100) begin tick; n++; end
    checks++;
    if (n != 13) begin
      failures++;
      $display("FAIL save_done_latency got=%0d want=13", n);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL save_busy_at_done got=%b want=0", busy);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[k] !== ev[k]) begin
        failures++;
        $display("FAIL save_mem%0d got=%h want=%h", k, mem[k], ev[k]);
      end
    end
    checks++;
    if (memwr_cnt - mw0 != 4) begin
      failures++;
      $display("FAIL save_mem_writes got=%0d want=4", memwr_cnt - mw0);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL save_after_done got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_load;
    int n;
    int w0, r0, l0, d0, o0;
    logic [5:0] li;
    logic [63:0] pv [4];
    pv[0] = 64'h1111_2222_3333_4444; pv[1] = 64'h5555_6666_7777_8888;
    pv[2] = 64'h0123_4567_89AB_CDEF; pv[3] = 64'hFEDC_BA98_7654_3210;
    set_mem(pv[0], pv[1], pv[2], pv[3]);
    load_slots(64'hAAAA_0000_0000_0000, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0003);
    w0 = wren_cnt; r0 = rst_cnt; l0 = load_cnt; d0 = done_cnt; o0 = overlap_cnt;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 200) begin tick; n++; end
    checks++;
    if (n != 11) begin
      failures++;
      $display("FAIL load_done_latency got=%0d want=11", n);
    end
    tick; tick; tick;
    checks++;
    if (rst_cnt - r0 != 1 || load_cnt - l0 != 1 || wren_cnt - w0 != 4) begin
      failures++;
      $display("FAIL load_strobe_counts got rst=%0d load=%0d wren=%0d want 1/1/4", rst_cnt - r0, load_cnt - l0, wren_cnt - w0);
    end
    for (int k = 0; k < 4; k++) begin
      li = 6'(w0 + k);
      checks++;
      if (wren_adr_log[li] !== 10'(k) || wren_din_log[li] !== pv[k]) begin
        failures++;
        $display("FAIL load_wren%0d got adr=%0h din=%h want adr=%0h din=%h", k, wren_adr_log[li], wren_din_log[li], k, pv[k]);
      end
      checks++;
      if (live[k] !== pv[k]) begin
        failures++;
        $display("FAIL load_live%0d got=%h want=%h", k, live[k], pv[k]);
      end
    end
    checks++;
    if (load_adr !== 10'd3 || load_din !== pv[3]) begin
      failures++;
      $display("FAIL load_strobe_bus got adr=%0h din=%h want adr=3 din=%h", load_adr, load_din, pv[3]);
    end
    checks++;
    if (overlap_cnt != o0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL load_overlap_done got overlap=%0d done=%0d want 0/1", overlap_cnt - o0, done_cnt - d0);
    end
  endtask

  task automatic test_both_and_busy;
    int n;
    int r0, mw0;
    logic [63:0] bv [4];
    bv[0] = 64'hB000_0000_0000_0001; bv[1] = 64'hB000_0000_0000_0002;
    bv[2] = 64'hB000_0000_0000_0003; bv[3] = 64'hB000_0000_0000_0004;
    load_slots(bv[0], bv[1], bv[2], bv[3]);
    set_mem(64'd0, 64'd0, 64'd0, 64'd0);
    r0 = rst_cnt; mw0 = memwr_cnt;
    save_req = 1'b1; load_req = 1'b1;
    tick;
    save_req = 1'b0; load_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || ss_rst !== 1'b0) begin
      failures++;
      $display("FAIL both_req_accept got busy=%b rst=%b want 1/0", busy, ss_rst);
    end
    tick; tick; tick;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick; n++; end
    tick; tick; tick; tick;
    checks++;
    if (rst_cnt != r0 || memwr_cnt - mw0 != 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL both_save_only got rst=%0d memwr=%0d busy=%b want 0/4/0", rst_cnt - r0, memwr_cnt - mw0, busy);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[k] !== bv[k]) begin
        failures++;
        $display("FAIL both_mem%0d got=%h want=%h", k, mem[k], bv[k]);
      end
    end
  endtask

  task automatic test_timeout;
    int n;
    int l0, d0;
    l0 = load_cnt_t; d0 = done_cnt_t;
    load_req_t = 1'b1;
    tick;
    load_req_t = 1'b0;
    n = 0;
    while (mem_rd_t !== 1'b1 && n < 10) begin tick; n++; end
    n = 0;
    while (error_t !== 1'b1 && n < 40) begin tick; n++; end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d want=8", n);
    end
    checks++;
    if (mem_rd_t !== 1'b0 || busy_t !== 1'b0 || done_t !== 1'b0) begin
      failures++;
      $display("FAIL timeout_abort got rd=%b busy=%b done=%b want 0/0/0", mem_rd_t, busy_t, done_t);
    end
    tick;
    checks++;
    if (error_t !== 1'b0) begin
      failures++;
      $display("FAIL timeout_error_width got=%b want=0", error_t);
    end
    // ack exactly on the last permitted wait cycle completes the read
    load_req_t = 1'b1;
    tick;
    load_req_t = 1'b0;
    n = 0;
    while (mem_rd_t !== 1'b1 && n < 10) begin tick; n++; end
    repeat (7) tick;
    mem_ack_t = 1'b1; mem_rdata_t = 64'hCAFE_F00D_1234_5678;
    tick;
    mem_ack_t = 1'b0;
    checks++;
    if (error_t !== 1'b0 || ss_wren_t !== 1'b1 || ss_adr_t !== 10'd0 || ss_din_t !== 64'hCAFE_F00D_1234_5678) begin
      failures++;
      $display("FAIL timeout_edge_ack got err=%b wren=%b adr=%0h din=%h want 0/1/0/cafef00d12345678", error_t, ss_wren_t, ss_adr_t, ss_din_t);
    end
    n = 0;
    while (error_t !== 1'b1 && n < 40) begin tick; n++; end
    tick;
    checks++;
    if (load_cnt_t != l0 || done_cnt_t != d0 || busy_t !== 1'b0) begin
      failures++;
      $display("FAIL timeout_no_load got load=%0d done=%0d busy=%b want 0/0/0", load_cnt_t - l0, done_cnt_t - d0, busy_t);
    end
    save_req_t = 1'b1;
    tick;
    save_req_t = 1'b0;
    checks++;
    if (busy_t !== 1'b1 || ss_rst_t !== 1'b0) begin
      failures++;
      $display("FAIL timeout_next_save got busy=%b rst=%b want 1/0", busy_t, ss_rst_t);
    end
    n = 0;
    while (mem_wr_t !== 1'b1 && n < 10) begin tick; n++; end
    n = 0;
    while (error_t !== 1'b1 && n < 40) begin tick; n++; end
    checks++;
    if (n != 8 || mem_wr_t !== 1'b0) begin
      failures++;
      $display("FAIL timeout_save_abort got cycles=%0d wr=%b want 8/0", n, mem_wr_t);
    end
  endtask

  task automatic test_reset_mid_load;
    int n;
    int l0, d0;
    set_mem(64'h0A0A_0000_0000_0000, 64'h0A0A_0000_0000_0001, 64'h0A0A_0000_0000_0002, 64'h0A0A_0000_0000_0003);
    l0 = load_cnt; d0 = done_cnt;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    n = 0;
    while (!(ss_wren === 1'b1 && ss_adr === 10'd2) && n < 50) begin tick; n++; end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL reset_mid_reach_slot2 got=timeout want=wren at adr 2");
    end
    reset_n = 1'b0;
    tick;
    checks++;
    if ({busy, done, error, ss_wren, ss_rst, ss_load, mem_rd, mem_wr} !== 8'd0 ||
        ss_adr !== 10'd0 || ss_din !== 64'd0 || mem_addr !== 16'd0 || mem_wdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got strobes=%b adr=%0h din=%h maddr=%0h want all 0",
               {busy, done, error, ss_wren, ss_rst, ss_load, mem_rd, mem_wr}, ss_adr, ss_din, mem_addr);
    end
    tick;
    reset_n = 1'b1;
    repeat (6) tick;
    checks++;
    if (load_cnt != l0 || done_cnt != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_load got load=%0d done=%0d busy=%b want 0/0/0", load_cnt - l0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_roundtrip;
    int n;
    logic [63:0] av [4];
    av[0] = 64'h7E57_0001_DEAD_BEEF; av[1] = 64'h0000_FFFF_0000_1234;
    av[2] = 64'h8000_0000_0000_0001; av[3] = 64'h3C3C_A5A5_5A5A_C3C3;
    rand_lat = 1'b1;
    load_slots(av[0], av[1], av[2], av[3]);
    save_req = 1'b1;
    tick;
    save_req = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin tick; n++; end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL roundtrip_save_done got=timeout want=done");
    end
    tick;
    load_slots(64'h1, 64'h2, 64'h3, 64'h4);
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin tick; n++; end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL roundtrip_load_done got done=%b err=%b want 1/0", done, error);
    end
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (slot_val[k] !== av[k] || live[k] !== av[k] || mem[k] !== av[k]) begin
        failures++;
        $display("FAIL roundtrip_slot%0d got slot=%h live=%h mem=%h want=%h", k, slot_val[k], live[k], mem[k], av[k]);
      end
    end
    rand_lat = 1'b0;
  endtask

  initial begin
    test_reset;
    test_save;
    test_load;
    test_both_and_busy;
    test_timeout;
    test_reset_mid_load;
    test_roundtrip;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
